// File: rtl/serial_pkg.sv
// Shared types and constants for the serial bit feeder.
// SERIAL_PARITY_EN adds one even-parity bit to every frame.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Number of serial bits emitted per accepted word.
  function automatic int frame_len(input int width);
`ifdef SERIAL_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down-counter that holds at zero; tracks the frame bits still to emit.
module bit_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end: WIDTH-bit words out MSB-first on x, idling high.
// SERIAL_PARITY_EN appends an even-parity bit after the LSB of each word.
module serial_bit_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          load_valid,
  output logic                          load_ready,
  output logic                          x,
  output logic                          x_valid,
  output logic                          busy,
  output logic [$clog2(WIDTH+2)-1:0]    bits_left
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = $clog2(WIDTH+2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             accept;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt;

`ifdef SERIAL_PARITY_EN
  logic parity_q, parity_d;

  always_comb begin
    parity_d = parity_q;
    if (accept) begin
      parity_d = ^data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  bit_down_counter #(
    .CNT_W (CNT_W)
  ) u_bit_down_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (CNT_LOAD),
    .dec        (cnt_dec),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  // x_q always holds the bit for the current cycle; shreg_q holds the bits after it.
  always_comb begin
    load_ready = (state_q == IDLE) || cnt_zero;
    accept     = load_valid && load_ready;
    state_d    = state_q;
    shreg_d    = shreg_q;
    x_d        = x_q;
    x_valid_d  = x_valid_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;

    if (accept) begin
      state_d   = SHIFT;
      shreg_d   = {data_in[WIDTH-2:0], 1'b0};
      x_d       = data_in[WIDTH-1];
      x_valid_d = 1'b1;
      cnt_load  = 1'b1;
    end else if ((state_q == SHIFT) && !cnt_zero) begin
      shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
      x_d       = shreg_q[WIDTH-1];
      x_valid_d = 1'b1;
      cnt_dec   = 1'b1;
`ifdef SERIAL_PARITY_EN
      if (cnt == CNT_W'(1)) begin
        x_d = parity_q;
      end
`endif
    end else begin
      state_d   = IDLE;
      x_d       = IDLE_LEVEL;
      x_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      x_q       <= IDLE_LEVEL;
      x_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
    end
  end

  assign x         = x_q;
  assign x_valid   = x_valid_q;
  assign busy      = (state_q == SHIFT);
  assign bits_left = cnt;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed self-checking bench for serial_bit_feeder (WIDTH=8 and WIDTH=4 instances).
module tb_serial_bit_feeder;

`ifdef SERIAL_PARITY_EN
  localparam int FL  = 9;
  localparam int FL4 = 5;
`else
  localparam int FL  = 8;
  localparam int FL4 = 4;
`endif

  logic       clock;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;
  logic       load_ready;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic [3:0] bits_left;

  logic [3:0] d4;
  logic       lv4;
  logic       lr4;
  logic       x4;
  logic       xv4;
  logic       busy4;
  logic [2:0] bl4;

  int errors = 0;
  int checks = 0;

  serial_bit_feeder #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .bits_left  (bits_left)
  );

  serial_bit_feeder #(.WIDTH(4)) dut4 (
    .clock      (clock),
    .reset      (reset),
    .data_in    (d4),
    .load_valid (lv4),
    .load_ready (lr4),
    .x          (x4),
    .x_valid    (xv4),
    .busy       (busy4),
    .bits_left  (bl4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_valid = 1'b0;
    data_in = 8'h00;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) reset = 1'b0;
      tick();
      checks++;
      if ({x, x_valid, busy, load_ready, bits_left} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd0}) begin
        errors++;
        $display("FAIL reset_idle c=%0d got x=%b v=%b busy=%b rdy=%b bl=%0d want x=1 v=0 busy=0 rdy=1 bl=0",
                 c, x, x_valid, busy, load_ready, bits_left);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] w;
    logic exp;
    w = 8'b0010_0000;
    data_in = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    data_in = 8'hFF;
    for (int i = 0; i < FL; i++) begin
      exp = (i < 8) ? w[7-i] : ^w;
      checks++;
      if ({x, x_valid, busy, load_ready, bits_left} !== {exp, 1'b1, 1'b1, (i == FL-1), 4'(FL-1-i)}) begin
        errors++;
        $display("FAIL single i=%0d got x=%b v=%b busy=%b rdy=%b bl=%0d want x=%b v=1 busy=1 rdy=%b bl=%0d",
                 i, x, x_valid, busy, load_ready, bits_left, exp, (i == FL-1), FL-1-i);
      end
      tick();
    end
    checks++;
    if ({x, x_valid, busy, load_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL single_end got x=%b v=%b busy=%b rdy=%b want x=1 v=0 busy=0 rdy=1",
               x, x_valid, busy, load_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    logic exp;
    int idx;
    data_in = 8'hA5;
    load_valid = 1'b1;
    tick();
    data_in = 8'h3C;
    for (int i = 0; i < 2*FL; i++) begin
      w   = (i < FL) ? 8'hA5 : 8'h3C;
      idx = i % FL;
      exp = (idx < 8) ? w[7-idx] : ^w;
      checks++;
      if ({x, x_valid, load_ready} !== {exp, 1'b1, (idx == FL-1)}) begin
        errors++;
        $display("FAIL b2b i=%0d got x=%b v=%b rdy=%b want x=%b v=1 rdy=%b",
                 i, x, x_valid, load_ready, exp, (idx == FL-1));
      end
      if (i == 2*FL-1) load_valid = 1'b0;
      tick();
    end
    checks++;
    if ({x, x_valid, busy, load_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL b2b_end got x=%b v=%b busy=%b rdy=%b want x=1 v=0 busy=0 rdy=1",
               x, x_valid, busy, load_ready);
    end
  endtask

  task automatic test_abort();
    logic [7:0] w;
    logic exp;
    data_in = 8'hFF;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({x, x_valid, busy, bits_left} !== {1'b1, 1'b1, 1'b1, 4'(FL-3)}) begin
      errors++;
      $display("FAIL abort_third got x=%b v=%b busy=%b bl=%0d want x=1 v=1 busy=1 bl=%0d",
               x, x_valid, busy, bits_left, FL-3);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({x, x_valid, busy, load_ready, bits_left} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL abort_reset got x=%b v=%b busy=%b rdy=%b bl=%0d want x=1 v=0 busy=0 rdy=1 bl=0",
               x, x_valid, busy, load_ready, bits_left);
    end
    w = 8'h01;
    data_in = w;
    load_valid = 1'b1;
    tick();
    checks++;
    if ({x_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL abort_drop got v=%b busy=%b want v=0 busy=0", x_valid, busy);
    end
    reset = 1'b0;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < FL; i++) begin
      exp = (i < 8) ? w[7-i] : ^w;
      checks++;
      if ({x, x_valid, bits_left} !== {exp, 1'b1, 4'(FL-1-i)}) begin
        errors++;
        $display("FAIL abort_reload i=%0d got x=%b v=%b bl=%0d want x=%b v=1 bl=%0d",
                 i, x, x_valid, bits_left, exp, FL-1-i);
      end
      tick();
    end
    checks++;
    if ({x, x_valid} !== 2'b10) begin
      errors++;
      $display("FAIL abort_end got x=%b v=%b want x=1 v=0", x, x_valid);
    end
  endtask

`ifdef SERIAL_PARITY_EN
  task automatic test_parity();
    logic [8:0] frames [2];
    frames[0] = 9'b0000_0111_1;
    frames[1] = 9'b0000_0011_0;
    for (int f = 0; f < 2; f++) begin
      data_in = frames[f][8:1];
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
        checks++;
        if ({x, x_valid} !== {frames[f][8-i], 1'b1}) begin
          errors++;
          $display("FAIL parity f=%0d i=%0d got x=%b v=%b want x=%b v=1",
                   f, i, x, x_valid, frames[f][8-i]);
        end
        tick();
      end
      checks++;
      if ({x, x_valid} !== 2'b10) begin
        errors++;
        $display("FAIL parity_end f=%0d got x=%b v=%b want x=1 v=0", f, x, x_valid);
      end
    end
  endtask
`endif

  task automatic test_width4();
    logic [4:0] bits;
    bits = 5'b1001_0;
    d4 = 4'b1001;
    lv4 = 1'b1;
    tick();
    lv4 = 1'b0;
    for (int i = 0; i < FL4; i++) begin
      checks++;
      if ({x4, xv4, bl4} !== {bits[4-i], 1'b1, 3'(FL4-1-i)}) begin
        errors++;
        $display("FAIL width4 i=%0d got x=%b v=%b bl=%0d want x=%b v=1 bl=%0d",
                 i, x4, xv4, bl4, bits[4-i], FL4-1-i);
      end
      tick();
    end
    checks++;
    if ({x4, xv4, busy4, lr4} !== 4'b1001) begin
      errors++;
      $display("FAIL width4_end got x=%b v=%b busy=%b rdy=%b want x=1 v=0 busy=0 rdy=1",
               x4, xv4, busy4, lr4);
    end
  endtask

  initial begin
    reset = 1'b1;
    load_valid = 1'b0;
    data_in = 8'h00;
    lv4 = 1'b0;
    d4 = 4'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
`ifdef SERIAL_PARITY_EN
    test_parity();
`endif
    test_width4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
